// File: rtl/usr_ctrl_pkg.sv
// Shared types for the universal shift-register serdes controller.
// FSM states and shift-register select codes.
package usr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TLOAD,
    TSHIFT,
    RCLR,
    RSHIFT,
    RHOLD
  } state_t;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SR   = 2'b01;
  localparam logic [1:0] SEL_SL   = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  function automatic logic [1:0] shift_sel(input logic dir);
    return dir ? SEL_SL : SEL_SR;
  endfunction

endpackage

// File: rtl/usr_serdes_ctrl.sv
// Serializer/deserializer controller driving an external
// universal shift register that updates on the falling edge.
module usr_serdes_ctrl
  import usr_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cfg_mode,
  input  logic             cfg_dir,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             sdo,
  output logic             sdo_en,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic             sdi_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic [1:0]       sr_select,
  output logic             sr_clr,
  output logic [WIDTH-1:0] sr_p_din,
  output logic             sr_s_left_din,
  output logic             sr_s_right_din,
  input  logic [WIDTH-1:0] sr_p_dout,
  input  logic             sr_s_left_dout,
  input  logic             sr_s_right_dout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             dir;
  logic [WIDTH-1:0] word;
  logic             clr_st;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      count  <= '0;
      dir    <= 1'b0;
      word   <= '0;
      sdo    <= 1'b0;
      sdo_en <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      // config is frozen once the controller leaves IDLE
      if (state == IDLE) dir <= cfg_dir;
      if (state == IDLE && tx_valid && !cfg_mode)
        word <= tx_data;
      sdo_en <= (state == TSHIFT);
      if (state == TSHIFT)
        sdo <= dir ? sr_s_left_dout : sr_s_right_dout;
      else
        sdo <= 1'b0;
    end
  end

  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    tx_ready       = 1'b0;
    sdi_ready      = 1'b0;
    rx_valid       = 1'b0;
    clr_st         = 1'b0;
    sr_select      = SEL_HOLD;
    sr_s_left_din  = 1'b0;
    sr_s_right_din = 1'b0;
    unique case (state)
      IDLE: begin
        tx_ready = ~cfg_mode;
        if (cfg_mode)      state_nxt = RCLR;
        else if (tx_valid) state_nxt = TLOAD;
      end
      TLOAD: begin
        sr_select = SEL_LOAD;
        count_nxt = '0;
        state_nxt = TSHIFT;
      end
      TSHIFT: begin
        sr_select = shift_sel(dir);
        count_nxt = count + ONE;
        if (count == LAST) state_nxt = IDLE;
      end
      RCLR: begin
        clr_st    = 1'b1;
        count_nxt = '0;
        state_nxt = RSHIFT;
      end
      RSHIFT: begin
        sdi_ready = 1'b1;
        if (sdi_valid) begin
          sr_select = shift_sel(dir);
          if (dir) sr_s_left_din  = sdi;
          else     sr_s_right_din = sdi;
          count_nxt = count + ONE;
          if (count == LAST) state_nxt = RHOLD;
        end
      end
      RHOLD: begin
        rx_valid = 1'b1;
        if (rx_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sr_clr   = clr_st | ~clr_n;
  assign sr_p_din = word;
  assign rx_data  = sr_p_dout;
  assign busy     = (state != IDLE);

endmodule
